// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared state encoding and defaults for the pipeline stall/flush sequencer
package pipe_ctrl_pkg;

    localparam int REG_AW_DEFAULT = 5;
    localparam int PERF_W_DEFAULT = 32;

    typedef logic [1:0] state_t;

    localparam state_t ST_RUN   = 2'd0;
    localparam state_t ST_DWAIT = 2'd1;
    localparam state_t ST_IDROP = 2'd2;

endpackage

// File: rtl/hazard_detect.sv
// rtl/hazard_detect.sv - combinational load-use hazard compare between ID sources and EX load destination
module hazard_detect #(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_mem_read,
    output logic              lu_hazard
);

    // x0 is hardwired zero, so a load targeting it can never feed a dependent instruction
    always_comb begin
        lu_hazard = ex_mem_read && (ex_rd != '0) && ((ex_rd == id_rs1) || (ex_rd == id_rs2));
    end

endmodule

// File: rtl/pipe_stall_ctrl.sv
// rtl/pipe_stall_ctrl.sv - stall/flush sequencer for the 5-stage core; optional stall counter under PIPE_PERF_CNT_EN
module pipe_stall_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_AW = REG_AW_DEFAULT
`ifdef PIPE_PERF_CNT_EN
    ,
    parameter int PERF_W = PERF_W_DEFAULT
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_mem_read,
    input  logic              ex_branch_tkn,
    input  logic              if_ready,
    input  logic              mem_req,
    input  logic              mem_ready,
    output logic              pc_load,
    output logic              if_id_load,
    output logic              if_id_flush,
    output logic              id_ex_load,
    output logic              id_ex_flush,
    output logic              ex_mem_load,
    output logic              mem_wb_load
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [PERF_W-1:0] stall_cnt
`endif
);

    state_t state;
    state_t state_nxt;
    logic   lu_hazard;
    logic   dmem_wait;
    logic   dropping;

    hazard_detect #(
        .REG_AW (REG_AW)
    ) u_hazard_detect (
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .ex_rd       (ex_rd),
        .ex_mem_read (ex_mem_read),
        .lu_hazard   (lu_hazard)
    );

    assign dmem_wait = mem_req && !mem_ready;
    assign dropping  = (state == ST_IDROP);

    // Fixed-priority resolution: DMEM wait, taken branch, load-use, IMEM wait / stale drop, normal
    always_comb begin
        pc_load     = 1'b0;
        if_id_load  = 1'b0;
        if_id_flush = 1'b0;
        id_ex_load  = 1'b0;
        id_ex_flush = 1'b0;
        ex_mem_load = 1'b0;
        mem_wb_load = 1'b0;
        state_nxt   = ST_RUN;
        if (rst) begin
            state_nxt = ST_RUN;
        end else if (dmem_wait) begin
            state_nxt = ST_DWAIT;
        end else if (ex_branch_tkn) begin
            pc_load     = 1'b1;
            if_id_load  = 1'b1;
            if_id_flush = 1'b1;
            id_ex_load  = 1'b1;
            id_ex_flush = 1'b1;
            ex_mem_load = 1'b1;
            mem_wb_load = 1'b1;
            // a fetch still outstanding (or a drop already pending) must be discarded when it lands
            state_nxt   = (dropping || !if_ready) ? ST_IDROP : ST_RUN;
        end else if (lu_hazard) begin
            id_ex_load  = 1'b1;
            id_ex_flush = 1'b1;
            ex_mem_load = 1'b1;
            mem_wb_load = 1'b1;
            state_nxt   = (dropping && !if_ready) ? ST_IDROP : ST_RUN;
        end else if (dropping || !if_ready) begin
            if_id_load  = 1'b1;
            if_id_flush = 1'b1;
            id_ex_load  = 1'b1;
            ex_mem_load = 1'b1;
            mem_wb_load = 1'b1;
            state_nxt   = (dropping && !if_ready) ? ST_IDROP : ST_RUN;
        end else begin
            pc_load     = 1'b1;
            if_id_load  = 1'b1;
            id_ex_load  = 1'b1;
            ex_mem_load = 1'b1;
            mem_wb_load = 1'b1;
            state_nxt   = ST_RUN;
        end
    end

    // State register; reset discards any pending wait or drop
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_RUN;
        end else begin
            state <= state_nxt;
        end
    end

`ifdef PIPE_PERF_CNT_EN
    // Count every cycle the PC is held, wrapping naturally at the counter width
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (!pc_load) begin
            stall_cnt <= stall_cnt + PERF_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// tb/tb_pipe_stall_ctrl.sv - directed and randomized checks of pipe_stall_ctrl against a rule-level model
module tb_pipe_stall_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       ex_mem_read, ex_branch_tkn, if_ready, mem_req, mem_ready;
    logic       pc_load, if_id_load, if_id_flush, id_ex_load, id_ex_flush, ex_mem_load, mem_wb_load;
`ifdef PIPE_PERF_CNT_EN
    logic [31:0] stall_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    // model state: a stale fetch is still owed to us and must be discarded
    bit          m_drop = 1'b0;
    logic [31:0] m_cnt  = '0;

    localparam logic [6:0] O_ZERO   = 7'b0000000;
    localparam logic [6:0] O_NORMAL = 7'b1101011;
    localparam logic [6:0] O_BRANCH = 7'b1111111;
    localparam logic [6:0] O_LOADUSE = 7'b0001111;
    localparam logic [6:0] O_IFWAIT = 7'b0111011;

    always #5 clk = ~clk;

    pipe_stall_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .id_rs1        (id_rs1),
        .id_rs2        (id_rs2),
        .ex_rd         (ex_rd),
        .ex_mem_read   (ex_mem_read),
        .ex_branch_tkn (ex_branch_tkn),
        .if_ready      (if_ready),
        .mem_req       (mem_req),
        .mem_ready     (mem_ready),
        .pc_load       (pc_load),
        .if_id_load    (if_id_load),
        .if_id_flush   (if_id_flush),
        .id_ex_load    (id_ex_load),
        .id_ex_flush   (id_ex_flush),
        .ex_mem_load   (ex_mem_load),
        .mem_wb_load   (mem_wb_load)
`ifdef PIPE_PERF_CNT_EN
        ,
        .stall_cnt     (stall_cnt)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // output vector {pc, if_id_load, if_id_flush, id_ex_load, id_ex_flush, ex_mem, mem_wb} from the priority rules
    function automatic logic [6:0] ref_outs(input bit r, input bit drop, input bit dwait,
                                            input bit br, input bit lu, input bit ifr);
        if (r || dwait) return O_ZERO;
        if (br)         return O_BRANCH;
        if (lu)         return O_LOADUSE;
        if (!ifr || drop) return O_IFWAIT;
        return O_NORMAL;
    endfunction

    // one clock: apply inputs, compare at the falling edge, advance the model at the rising edge
    task automatic cyc(input string tag, input bit r, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input bit mr, input bit br, input bit ifr,
                       input bit mq, input bit mrdy, input bit directed, input logic [6:0] expv);
        logic [6:0] m;
        bit lu;
        rst = r; id_rs1 = rs1; id_rs2 = rs2; ex_rd = rd;
        ex_mem_read = mr; ex_branch_tkn = br; if_ready = ifr; mem_req = mq; mem_ready = mrdy;
        #4;
        lu = mr && (rd != 0) && (rd == rs1 || rd == rs2);
        m  = ref_outs(r, m_drop, mq && !mrdy, br, lu, ifr);
        check(tag, {25'd0, pc_load, if_id_load, if_id_flush, id_ex_load, id_ex_flush, ex_mem_load, mem_wb_load},
              {25'd0, (directed ? expv : m)});
`ifdef PIPE_PERF_CNT_EN
        check({tag, "_cnt"}, stall_cnt, m_cnt);
`endif
        if (r || (mq && !mrdy)) m_drop = 1'b0;
        else if (br)            m_drop = m_drop || !ifr;
        else if (ifr)           m_drop = 1'b0;
        if (r)            m_cnt = '0;
        else if (!m[6])   m_cnt = m_cnt + 1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        @(posedge clk);
        #1;
        // reset state
        cyc("reset",     1, 0, 0, 0, 0, 0, 1, 0, 0, 1, O_ZERO);
        cyc("normal",    0, 1, 2, 3, 0, 0, 1, 0, 0, 1, O_NORMAL);
        // load-use, single bubble
        cyc("lu_stall",  0, 5, 0, 5, 1, 0, 1, 0, 0, 1, O_LOADUSE);
        cyc("lu_after",  0, 5, 0, 7, 0, 0, 1, 0, 0, 1, O_NORMAL);
        cyc("lu_rs2",    0, 1, 9, 9, 1, 0, 1, 0, 0, 1, O_LOADUSE);
        // x0 destination never stalls
        cyc("x0_nostall",0, 0, 0, 0, 1, 0, 1, 0, 0, 1, O_NORMAL);
        // data memory wait for three cycles then completion
        for (int i = 0; i < 3; i++)
            cyc("dwait",  0, 1, 2, 3, 0, 0, 1, 1, 0, 1, O_ZERO);
        cyc("dwait_done",0, 1, 2, 3, 0, 0, 1, 1, 1, 1, O_NORMAL);
        cyc("dwait_run", 0, 1, 2, 3, 0, 0, 1, 0, 0, 1, O_NORMAL);
        // branch beats load-use
        cyc("br_lu",     0, 5, 0, 5, 1, 1, 1, 0, 0, 1, O_BRANCH);
        cyc("br_lu_run", 0, 1, 2, 3, 0, 0, 1, 0, 0, 1, O_NORMAL);
        // branch with fetch outstanding: drop the stale return
        cyc("br_idrop",  0, 1, 2, 3, 0, 1, 0, 0, 0, 1, O_BRANCH);
        cyc("idrop_wait",0, 1, 2, 3, 0, 0, 0, 0, 0, 1, O_IFWAIT);
        cyc("idrop_ret", 0, 1, 2, 3, 0, 0, 1, 0, 0, 1, O_IFWAIT);
        cyc("idrop_run", 0, 1, 2, 3, 0, 0, 1, 0, 0, 1, O_NORMAL);
        // new branch while dropping stays in drop even with fetch returning
        cyc("br2_a",     0, 1, 2, 3, 0, 1, 0, 0, 0, 1, O_BRANCH);
        cyc("br2_b",     0, 1, 2, 3, 0, 1, 1, 0, 0, 1, O_BRANCH);
        cyc("br2_ret",   0, 1, 2, 3, 0, 0, 1, 0, 0, 1, O_IFWAIT);
        cyc("br2_run",   0, 1, 2, 3, 0, 0, 1, 0, 0, 1, O_NORMAL);
        // reset in the middle of a memory wait
        cyc("rdw_wait",  0, 1, 2, 3, 0, 0, 1, 1, 0, 1, O_ZERO);
        cyc("rdw_rst",   1, 1, 2, 3, 0, 0, 1, 1, 0, 1, O_ZERO);
        cyc("rdw_run",   0, 1, 2, 3, 0, 0, 1, 0, 0, 1, O_NORMAL);
        // reset in the middle of a drop forgets the stale fetch
        cyc("rdr_br",    0, 1, 2, 3, 0, 1, 0, 0, 0, 1, O_BRANCH);
        cyc("rdr_rst",   1, 1, 2, 3, 0, 0, 0, 0, 0, 1, O_ZERO);
        cyc("rdr_run",   0, 1, 2, 3, 0, 0, 1, 0, 0, 1, O_NORMAL);

        // randomized traffic against the model
        cyc("rnd_rst", 1, 0, 0, 0, 0, 0, 1, 0, 0, 1, O_ZERO);
        for (int i = 0; i < 3000; i++) begin
            cyc("rnd",
                ($urandom_range(0, 49) == 0),
                5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                ($urandom_range(0, 1) == 1),
                ($urandom_range(0, 5) == 0),
                ($urandom_range(0, 9) < 7),
                ($urandom_range(0, 9) < 3),
                ($urandom_range(0, 1) == 1),
                0, O_ZERO);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
